// File: rtl/mem_scheduler_pkg.sv
// mem_scheduler_pkg: shared types and address map for the DDR4 request scheduler
package mem_scheduler_pkg;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_IFETCH} parsed_op_t;
    typedef enum logic [2:0] {NOP, ACT, RD, WR, PRE} dram_cmd_t;
    typedef enum logic [1:0] {S_IDLE, S_ACT_WAIT, S_RW_WAIT, S_PRE_WAIT} sched_states_t;
    localparam int COL_LO_LSB = 3;
    localparam int COL_LO_W = 3;
    localparam int BG_LSB = 6;
    localparam int BG_W = 2;
    localparam int BANK_LSB = 8;
    localparam int BANK_W = 2;
    localparam int COL_HI_LSB = 10;
    localparam int COL_HI_W = 8;
    localparam int ROW_LSB = 18;
    localparam int ROW_W = 14;
    localparam int COL_W = COL_HI_W + COL_LO_W;
    typedef struct packed {
        parsed_op_t op;
        logic [BG_W-1:0] bg;
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } dram_req_t;
    function automatic int max2(int a, int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/mem_scheduler_if.sv
// mem_scheduler_if: parser-side op input and command-side output bundle of the scheduler
interface mem_scheduler_if import mem_scheduler_pkg::*; #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int QUEUE_DEPTH = 16
);
    logic op_ready_s;
    parsed_op_t opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    logic queue_full;
    logic overflow_s;
    logic [$clog2(QUEUE_DEPTH):0] pending;
    logic cmd_valid;
    dram_cmd_t cmd;
    logic [1:0] cmd_bg;
    logic [1:0] cmd_bank;
    logic [13:0] cmd_row;
    logic [10:0] cmd_col;
    modport master (
        output op_ready_s, opcode, address,
        input queue_full, overflow_s, pending, cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col
    );
    modport slave (
        input op_ready_s, opcode, address,
        output queue_full, overflow_s, pending, cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col
    );
endinterface

// File: rtl/mem_scheduler_req_fifo.sv
// mem_req_fifo: in-order request queue; the head stays stable until it is popped
module mem_req_fifo import mem_scheduler_pkg::*; #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input dram_req_t din,
    output dram_req_t dout,
    output logic full,
    output logic empty,
    output logic [AW:0] count
);
    dram_req_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/mem_scheduler.sv
// mem_scheduler: in-order closed-page DDR4 scheduler issuing ACT -> RD/WR -> PRE under DRAM timing
module mem_scheduler import mem_scheduler_pkg::*; #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int QUEUE_DEPTH = 16,
    parameter int T_RCD = 24,
    parameter int T_RAS = 52,
    parameter int T_CL = 24,
    parameter int T_CWL = 20,
    parameter int T_BURST = 4,
    parameter int T_WR = 20,
    parameter int T_RP = 24
) (
    input logic clk,
    input logic rst_n,
    mem_scheduler_if.slave bus
);
    localparam int T_MAX = max2(max2(max2(T_RCD, T_RAS), max2(T_CL, T_CWL)), max2(T_WR, T_RP));
    localparam int TW = $clog2(T_MAX + T_CL + T_BURST + T_WR + 1);
    localparam int QW = $clog2(QUEUE_DEPTH);
    sched_states_t state, state_nxt;
    dram_cmd_t cmd_nxt;
    dram_req_t req_in, head;
    logic [TW-1:0] ras_tmr, ph_tmr, ph_nxt;
    logic [QW:0] count;
    logic full, empty, push, pop, is_wr;
    logic ras_done, ph_done, issue_act, issue_rw, issue_pre;
    logic addr_unused;
    assign addr_unused = ^bus.address[COL_LO_LSB-1:0];
    assign req_in = '{
        op: bus.opcode,
        bg: bus.address[BG_LSB +: BG_W],
        bank: bus.address[BANK_LSB +: BANK_W],
        row: bus.address[ROW_LSB +: ROW_W],
        col: {bus.address[COL_HI_LSB +: COL_HI_W], bus.address[COL_LO_LSB +: COL_LO_W]}
    };
    assign push = bus.op_ready_s && !full;
    assign bus.queue_full = full;
    assign bus.pending = count;
    mem_req_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .din(req_in),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
    assign is_wr = head.op == OP_WRITE;
    assign ras_done = ras_tmr == '0;
    assign ph_done = ph_tmr == '0;
    assign issue_act = !empty && (state == S_IDLE || (state == S_PRE_WAIT && ph_done));
    assign issue_rw = state == S_ACT_WAIT && ph_done;
    assign issue_pre = state == S_RW_WAIT && ras_done && ph_done;
    assign pop = issue_pre;
    always_comb
        state_nxt = issue_act ? S_ACT_WAIT :
                    issue_rw ? S_RW_WAIT :
                    issue_pre ? S_PRE_WAIT :
                    (state == S_PRE_WAIT && ph_done) ? S_IDLE : state;
    // Timers load (interval-1) at issue so the next command lands exactly interval clocks later.
    always_comb begin
        cmd_nxt = issue_act ? ACT : issue_rw ? (is_wr ? WR : RD) : issue_pre ? PRE : NOP;
        ph_nxt = issue_act ? TW'(T_RCD - 1) :
                 issue_rw ? (is_wr ? TW'(T_CWL + T_BURST + T_WR - 1) : TW'(T_CL + T_BURST - 1)) :
                 issue_pre ? TW'(T_RP - 1) :
                 ph_done ? ph_tmr : ph_tmr - TW'(1);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= S_IDLE;
            ras_tmr <= '0;
            ph_tmr <= '0;
        end else begin
            state <= state_nxt;
            ras_tmr <= issue_act ? TW'(T_RAS - 1) : ras_done ? ras_tmr : ras_tmr - TW'(1);
            ph_tmr <= ph_nxt;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.cmd_valid <= 1'b0;
            bus.cmd <= NOP;
            bus.cmd_bg <= '0;
            bus.cmd_bank <= '0;
            bus.cmd_row <= '0;
            bus.cmd_col <= '0;
            bus.overflow_s <= 1'b0;
        end else begin
            bus.cmd_valid <= cmd_nxt != NOP;
            bus.cmd <= cmd_nxt;
            bus.cmd_bg <= cmd_nxt == NOP ? '0 : head.bg;
            bus.cmd_bank <= cmd_nxt == NOP ? '0 : head.bank;
            bus.cmd_row <= issue_act ? head.row : '0;
            bus.cmd_col <= issue_rw ? head.col : '0;
            bus.overflow_s <= bus.op_ready_s && full;
        end
endmodule

// File: tb/tb_mem_scheduler.sv
// tb_mem_scheduler: table vectors plus scoreboard-checked multi-cycle scenarios for mem_scheduler
module tb_mem_scheduler;
    import mem_scheduler_pkg::*;
    typedef struct {
        dram_cmd_t cmd;
        logic [1:0] bg;
        logic [1:0] bank;
        logic [13:0] row;
        logic [10:0] col;
        int at;
    } ev_t;
    typedef struct {
        parsed_op_t op;
        logic [31:0] addr;
        logic [1:0] bg;
        logic [1:0] bank;
        logic [13:0] row;
        logic [10:0] col;
        int pre_at;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int n_cmd = 0;
    ev_t sb[$];
    ev_t e;
    vec_t vecs[5];
    mem_scheduler_if #(.ADDRESS_WIDTH(32), .QUEUE_DEPTH(16)) bus();
    mem_scheduler dut(.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    function automatic void expect_req(parsed_op_t op, logic [31:0] a, int t_act, int t_rw, int t_pre);
        logic [1:0] bg = 2'((a >> 6) & 32'd3);
        logic [1:0] bank = 2'((a >> 8) & 32'd3);
        logic [13:0] row = 14'(a >> 18);
        logic [10:0] col = 11'((((a >> 10) & 32'hFF) << 3) | ((a >> 3) & 32'd7));
        sb.push_back('{ACT, bg, bank, row, 11'd0, t_act});
        sb.push_back('{op == OP_WRITE ? WR : RD, bg, bank, 14'd0, col, t_rw});
        sb.push_back('{PRE, bg, bank, 14'd0, 11'd0, t_pre});
    endfunction
    always @(negedge clk)
        if (rst_n && bus.cmd_valid) begin
            n_cmd++;
            if (sb.size() == 0) check("unexpected_cmd", bus.cmd, NOP);
            else begin
                e = sb.pop_front();
                check("cmd", bus.cmd, e.cmd);
                check("cmd_fields", {bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col}, {e.bg, e.bank, e.row, e.col});
                if (e.at >= 0) check("cmd_cycle", cyc, e.at);
            end
        end
    task automatic send(input parsed_op_t op, input logic [31:0] a, output int acc);
        @(negedge clk);
        bus.op_ready_s = 1'b1;
        bus.opcode = op;
        bus.address = a;
        @(posedge clk);
        #1 acc = cyc;
    endtask
    task automatic release_op();
        @(negedge clk);
        bus.op_ready_s = 1'b0;
    endtask
    task automatic wait_until(input int t);
        do @(negedge clk); while (cyc < t);
    endtask
    task automatic drain(input int limit, input string name);
        int n = 0;
        while ((sb.size() != 0 || bus.pending != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, sb.size(), 0);
        repeat (32) @(negedge clk);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int a0, acc, n0, sent;
        parsed_op_t op;
        logic [31:0] a;
        vecs[0] = '{OP_READ, 32'h0004_6B40, 2'd1, 2'd3, 14'd1, 11'h0D0, 53};
        vecs[1] = '{OP_WRITE, 32'h0000_0000, 2'd0, 2'd0, 14'd0, 11'h000, 69};
        vecs[2] = '{OP_IFETCH, 32'hFFFF_FFFF, 2'd3, 2'd3, 14'h3FFF, 11'h7FF, 53};
        vecs[3] = '{OP_WRITE, 32'h1234_5678, 2'd1, 2'd2, 14'h048D, 11'h0AF, 69};
        vecs[4] = '{OP_READ, 32'h8000_0038, 2'd0, 2'd0, 14'h2000, 11'h007, 53};
        bus.op_ready_s = 1'b0;
        bus.opcode = OP_READ;
        bus.address = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_valid", bus.cmd_valid, 0);
        check("rst_cmd", bus.cmd, NOP);
        check("rst_pending", bus.pending, 0);
        check("rst_queue_full", bus.queue_full, 0);
        check("rst_overflow", bus.overflow_s, 0);
        check("rst_fields", {bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].addr, a0);
            sb.push_back('{ACT, vecs[i].bg, vecs[i].bank, vecs[i].row, 11'd0, a0 + 1});
            sb.push_back('{vecs[i].op == OP_WRITE ? WR : RD, vecs[i].bg, vecs[i].bank, 14'd0, vecs[i].col, a0 + 25});
            sb.push_back('{PRE, vecs[i].bg, vecs[i].bank, 14'd0, 11'd0, a0 + vecs[i].pre_at});
            release_op();
            drain(200, "vec_drain");
        end
        send(OP_READ, 32'h0004_6B40, a0);
        expect_req(OP_READ, 32'h0004_6B40, a0 + 1, a0 + 25, a0 + 53);
        send(OP_READ, 32'h0008_00C0, acc);
        expect_req(OP_READ, 32'h0008_00C0, a0 + 77, a0 + 101, a0 + 129);
        release_op();
        wait_until(a0 + 52);
        check("b2b_pending_before_pre", bus.pending, 2);
        @(negedge clk);
        check("b2b_pending_at_pre", bus.pending, 1);
        drain(300, "b2b_drain");
        for (int i = 0; i < 17; i++) begin
            a = (32'(i) << 18) | (32'(i % 4) << 6) | (32'((i + 1) % 4) << 8) | (32'(i % 8) << 3);
            send(OP_READ, a, acc);
            if (i == 0) a0 = acc;
            if (i < 16) expect_req(OP_READ, a, i == 0 ? a0 + 1 : -1, i == 0 ? a0 + 25 : -1, i == 0 ? a0 + 53 : -1);
            if (i == 15) begin
                check("full_after_16", bus.queue_full, 1);
                check("pending_16", bus.pending, 16);
                check("no_overflow_yet", bus.overflow_s, 0);
            end
            if (i == 16) begin
                check("overflow_pulse", bus.overflow_s, 1);
                check("pending_after_drop", bus.pending, 16);
            end
        end
        release_op();
        @(negedge clk);
        check("overflow_single_cycle", bus.overflow_s, 0);
        wait_until(a0 + 52);
        check("full_before_pre", bus.queue_full, 1);
        bus.op_ready_s = 1'b1;
        bus.opcode = OP_WRITE;
        bus.address = 32'h00FF_FFC0;
        @(posedge clk);
        #1;
        check("pre_cycle_drop_overflow", bus.overflow_s, 1);
        check("pre_cycle_pending", bus.pending, 15);
        release_op();
        drain(2000, "overflow_drain");
        sent = 0;
        n0 = 0;
        while (sent < 40 && n0 < 20000) begin
            @(negedge clk);
            n0++;
            bus.op_ready_s = bus.pending < 8;
            if (bus.pending < 8) begin
                op = parsed_op_t'(sent % 3);
                a = $urandom;
                bus.opcode = op;
                bus.address = a;
                expect_req(op, a, -1, -1, -1);
                sent++;
            end
        end
        release_op();
        check("wrap_sent", sent, 40);
        drain(5000, "wrap_drain");
        send(OP_READ, 32'h0004_6B40, a0);
        expect_req(OP_READ, 32'h0004_6B40, a0 + 1, a0 + 25, a0 + 53);
        send(OP_WRITE, 32'h0012_3440, acc);
        release_op();
        wait_until(a0 + 25);
        #1 check("rd_before_reset", bus.cmd_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("reset_cmd_valid", bus.cmd_valid, 0);
        check("reset_cmd", bus.cmd, NOP);
        check("reset_pending", bus.pending, 0);
        check("reset_queue_full", bus.queue_full, 0);
        sb.delete();
        n0 = n_cmd;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("no_cmd_after_reset", n_cmd - n0, 0);
        check("pending_after_reset", bus.pending, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
